// File: rtl/imm_ext_pipe.sv
// -----------------------------------------------------------------------------
// imm_ext_pipe
//
// Pipelined immediate extender for the decode stage. An accepted raw
// immediate is widened to DATA_W bits in the mode selected by ext_op and
// handed downstream through a valid/ready handshake. A two-entry buffer
// (output register OUT plus skid register SKID) absorbs execute-stage stalls
// so that no operand is ever dropped or duplicated, and entries always leave
// in the order they were accepted.
//
// Extension modes (ext_op):
//   000  imm placed in the top IMM_W bits (imm << (DATA_W-IMM_W))
//   001  zero-extend
//   010  sign-extend from imm[IMM_W-1]
//   011  constant CONST_VAL (truncated or zero-padded to DATA_W)
//   100  sign-extend then << 2   (branch offset; needs IMM_EXT_BRANCH_EN)
//   101  zero-extend then << 2   (jump index;    needs IMM_EXT_BRANCH_EN)
//   110/111 illegal: result 0, sets the sticky illegal_op flag
// Shifted-out bits beyond DATA_W are discarded, there is no saturation.
//
// Build option:
//   IMM_EXT_BRANCH_EN  defined  -> modes 100/101 are the scaled offsets above
//                      undefined -> modes 100/101 are illegal and the
//                                   offset-scaling logic is not built
//
// Parameters:
//   DATA_W     output width, must satisfy DATA_W >= IMM_W + 2
//   IMM_W      raw immediate width
//   CONST_VAL  value produced by mode 011
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset, clears all state immediately
//   in_valid    upstream presents an immediate
//   in_ready    block can accept this cycle (registered, = !skid valid)
//   imm         raw immediate
//   ext_op      extension mode
//   flush       synchronous discard of every buffered entry, highest priority
//   out_valid   extended holds a valid result
//   out_ready   downstream accepts the result this cycle
//   extended    extended result
//   illegal_op  sticky: an illegal ext_op was accepted (cleared by rst_n only)
// -----------------------------------------------------------------------------
module imm_ext_pipe #(
    parameter int          DATA_W    = 32,
    parameter int          IMM_W     = 16,
    parameter logic [31:0] CONST_VAL = 32'h0000_1234
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  imm,
    input  logic [2:0]        ext_op,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] extended,
    output logic              illegal_op
);

    // Constant mode value, zero-padded or truncated to the datapath width.
    localparam logic [DATA_W-1:0] CONST_EXT = DATA_W'(CONST_VAL);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic              skid_valid_r;
    logic [DATA_W-1:0] skid_data_r;
    logic              illegal_r;

    logic              out_valid_nx_s;
    logic [DATA_W-1:0] out_data_nx_s;
    logic              skid_valid_nx_s;
    logic [DATA_W-1:0] skid_data_nx_s;
    logic              illegal_nx_s;

    // ------------------------------------------------------------------
    // Extension datapath
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] zext_s;
    logic [DATA_W-1:0] sext_s;
    logic [DATA_W-1:0] high_s;
    logic [DATA_W-1:0] result_s;
    logic              op_illegal_s;
    logic              accept_s;

    // Basic widenings shared by several modes.
    always_comb begin
        zext_s = {{(DATA_W-IMM_W){1'b0}}, imm};
        sext_s = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        high_s = {imm, {(DATA_W-IMM_W){1'b0}}};
    end

    // Mode select; anything not listed (including 100/101 when offset
    // scaling is not built) yields zero and is flagged illegal.
    always_comb begin
        result_s     = {DATA_W{1'b0}};
        op_illegal_s = 1'b0;
        case (ext_op)
            3'b000: result_s = high_s;
            3'b001: result_s = zext_s;
            3'b010: result_s = sext_s;
            3'b011: result_s = CONST_EXT;
`ifdef IMM_EXT_BRANCH_EN
            3'b100: result_s = {sext_s[DATA_W-3:0], 2'b00};
            3'b101: result_s = {zext_s[DATA_W-3:0], 2'b00};
`endif
            default: begin
                result_s     = {DATA_W{1'b0}};
                op_illegal_s = 1'b1;
            end
        endcase
    end

    // in_ready comes straight from the skid valid register, so there is no
    // combinational path from out_ready back to the upstream stage.
    assign in_ready = ~skid_valid_r;
    assign accept_s = in_valid & ~skid_valid_r;

    // ------------------------------------------------------------------
    // Buffer next-state
    // ------------------------------------------------------------------
    // Decide where the accepted entry goes and how OUT/SKID advance.
    always_comb begin
        out_valid_nx_s  = out_valid_r;
        out_data_nx_s   = out_data_r;
        skid_valid_nx_s = skid_valid_r;
        skid_data_nx_s  = skid_data_r;
        if (flush) begin
            // Discard everything, including a same-cycle accept. The data
            // registers keep their values; they are don't-care once invalid.
            out_valid_nx_s  = 1'b0;
            skid_valid_nx_s = 1'b0;
        end else if (out_ready && skid_valid_r) begin
            // SKID drains into OUT. in_ready was low, so no accept now.
            out_valid_nx_s  = 1'b1;
            out_data_nx_s   = skid_data_r;
            skid_valid_nx_s = 1'b0;
        end else if (!out_valid_r || out_ready) begin
            // OUT is empty or being consumed while SKID is empty.
            if (accept_s) begin
                out_valid_nx_s = 1'b1;
                out_data_nx_s  = result_s;
            end else begin
                out_valid_nx_s = 1'b0;
            end
        end else begin
            // Stalled with OUT occupied: a new entry parks in SKID.
            if (accept_s) begin
                skid_valid_nx_s = 1'b1;
                skid_data_nx_s  = result_s;
            end else begin
                skid_valid_nx_s = skid_valid_r;
            end
        end
    end

    // Sticky illegal flag: set on any accepted illegal op, flush or not.
    always_comb begin
        if (accept_s && op_illegal_s) begin
            illegal_nx_s = 1'b1;
        end else begin
            illegal_nx_s = illegal_r;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // Buffer and flag registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {DATA_W{1'b0}};
            skid_valid_r <= 1'b0;
            skid_data_r  <= {DATA_W{1'b0}};
            illegal_r    <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_nx_s;
            out_data_r   <= out_data_nx_s;
            skid_valid_r <= skid_valid_nx_s;
            skid_data_r  <= skid_data_nx_s;
            illegal_r    <= illegal_nx_s;
        end
    end

    // Outputs are driven directly from registers.
    assign out_valid  = out_valid_r;
    assign extended   = out_data_r;
    assign illegal_op = illegal_r;

endmodule

// File: tb/tb_imm_ext_pipe.sv
module tb_imm_ext_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] imm;
    logic [2:0]  ext_op;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] extended;
    logic        illegal_op;

    int total;
    int bad;
    int pops;
    logic [31:0] sb[$];

    imm_ext_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imm        (imm),
        .ext_op     (ext_op),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .extended   (extended),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every handshake pops the oldest expected value and compares.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            pops++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: got %h expected none", extended);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                if (extended !== e) begin
                    bad++;
                    $display("FAIL out_data: got %h expected %h", extended, e);
                end
            end
        end
    end

    // Present one immediate; record its expected result when it is accepted.
    task automatic send(input logic [2:0] op, input logic [15:0] v, input logic [31:0] exp);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        ext_op   = op;
        imm      = v;
        while (!ok && n < 60) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else n++;
        end
        if (ok) begin
            sb.push_back(exp);
        end else begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 60 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] exp_b0, exp_b1;
        logic        exp_ill;
        int          p0;

        total = 0; bad = 0; pops = 0;
        rst_n = 1'b0; in_valid = 1'b0; imm = 16'h0000; ext_op = 3'b000;
        flush = 1'b0; out_ready = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_extended", extended, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_illegal", 32'(illegal_op), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Streaming at full rate over the basic modes.
        out_ready = 1'b1;
        p0 = pops;
        send(3'b000, 16'h8001, 32'h8001_0000);
        send(3'b001, 16'h8001, 32'h0000_8001);
        send(3'b010, 16'h8001, 32'hFFFF_8001);
        send(3'b011, 16'h8001, 32'h0000_1234);
        @(posedge clk); #1;
        chk("stream_pops", 32'(pops - p0), 32'd4);
        chk("stream_idle_valid", 32'(out_valid), 32'd0);
        chk("stream_illegal", 32'(illegal_op), 32'd0);

        // Branch / jump offset modes.
`ifdef IMM_EXT_BRANCH_EN
        exp_b0 = 32'hFFFF_FFFC; exp_b1 = 32'h0003_FFFC; exp_ill = 1'b0;
`else
        exp_b0 = 32'h0; exp_b1 = 32'h0; exp_ill = 1'b1;
`endif
        send(3'b100, 16'hFFFF, exp_b0);
        send(3'b101, 16'hFFFF, exp_b1);
        drain();
        chk("branch_illegal", 32'(illegal_op), 32'(exp_ill));

        // Stall: A in OUT, B in SKID, C held upstream.
        out_ready = 1'b0;
        send(3'b001, 16'h1234, 32'h0000_1234);
        send(3'b010, 16'h8000, 32'hFFFF_8000);
        fork
            send(3'b000, 16'h00AB, 32'h00AB_0000);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_hold", extended, 32'h0000_1234);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        @(posedge clk); #1;
        chk("stall_done_valid", 32'(out_valid), 32'd0);

        // Flush with a full skid and a pending input.
        out_ready = 1'b0;
        send(3'b001, 16'h0011, 32'h0000_0011);
        send(3'b001, 16'h0022, 32'h0000_0022);
        in_valid = 1'b1; ext_op = 3'b001; imm = 16'h0033;
        flush = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        p0 = pops;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("flush_nothing_out", 32'(pops - p0), 32'd0);

        // Illegal op and stickiness.
        @(posedge clk); #1;
        send(3'b111, 16'h1234, 32'h0);
        drain();
        chk("illegal_set", 32'(illegal_op), 32'd1);
        send(3'b001, 16'h0005, 32'h0000_0005);
        drain();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("illegal_sticky", 32'(illegal_op), 32'd1);

        // Asynchronous reset in the middle of a stalled stream.
        out_ready = 1'b0;
        send(3'b010, 16'h7FFF, 32'h0000_7FFF);
        send(3'b010, 16'hF000, 32'hFFFF_F000);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_illegal", 32'(illegal_op), 32'd0);
        chk("arst_extended", extended, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        p0 = pops;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("arst_nothing_out", 32'(pops - p0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
